adc_lane_align: RTL and testbench



---
 rtl/adc_if_pkg.sv | 31 +++
 rtl/adc_lane_align_if.sv | 27 ++
 rtl/adc_lane_delay.sv | 41 ++++
 rtl/adc_lane_align.sv | 165 ++++++++++++++++
 tb/tb_adc_lane_align.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_if_pkg.sv
// Shared ADC interface package: aligner state encoding and width helpers.
package adc_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SEARCH = 3'd2,
        ST_APPLY  = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_t;

    // Number of bits needed to index 'value' distinct items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned delay_w(input int unsigned max_delay);
        return clog2(max_delay + 1);
    endfunction

    function automatic int unsigned word_w(input int unsigned data_w, input int unsigned spw);
        return data_w * spw;
    endfunction

endpackage

// File: rtl/adc_lane_align_if.sv
// Signal bundle of the lane aligner: control/data towards it and status back.
interface adc_lane_align_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WORD_W = adc_if_pkg::word_w(8, 4),
    parameter int unsigned DW     = adc_if_pkg::delay_w(7)
);
    logic [NUM_CH*WORD_W-1:0] din;
    logic                     train_start;
    logic [NUM_CH*DW-1:0]     manual_delay;
    logic                     manual_load;
    logic [NUM_CH*WORD_W-1:0] dout;
    logic                     dout_valid;
    logic [NUM_CH*DW-1:0]     delay_out;
    logic                     busy;
    logic                     locked;
    logic                     fail;

    modport master (
        output din, train_start, manual_delay, manual_load,
        input  dout, dout_valid, delay_out, busy, locked, fail
    );

    modport slave (
        input  din, train_start, manual_delay, manual_load,
        output dout, dout_valid, delay_out, busy, locked, fail
    );
endinterface

// File: rtl/adc_lane_delay.sv
// One channel's programmable delay: din delayed by 1 + delay_i clk cycles.
module adc_lane_delay #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_DELAY = 7,
    parameter int unsigned DW        = 3
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic [DW-1:0]    delay_i,
    output logic [WIDTH-1:0] dout_o
);

    // din itself is tap 0, so the shift stages only hold taps 1..MAX_DELAY
    logic [WIDTH-1:0] sr_q [1:MAX_DELAY];
    logic [WIDTH-1:0] tap_d;
    logic [WIDTH-1:0] dout_q;

    // Tap select: the registered output adds the one mandatory cycle
    always_comb begin
        tap_d = din_i;
        for (int unsigned i = 1; i <= MAX_DELAY; i++) begin
            if (delay_i == DW'(i)) tap_d = sr_q[i];
        end
    end

    // Shift register and registered tap
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sr_q   <= '{default: '0};
            dout_q <= '0;
        end else begin
            sr_q[1] <= din_i;
            for (int unsigned i = 2; i <= MAX_DELAY; i++) sr_q[i] <= sr_q[i-1];
            dout_q <= tap_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/adc_lane_align.sv
// Multi-channel ADC lane aligner: per-channel delay lines trained on a sync marker
// or loaded manually. Optional macro ADC_TWOS_COMP_EN inverts each sample MSB on dout.
module adc_lane_align
    import adc_if_pkg::*;
#(
    parameter int unsigned                NUM_CH           = 4,
    parameter int unsigned                ADC_DATA_WIDTH   = 8,
    parameter int unsigned                SAMPLES_PER_WORD = 4,
    parameter int unsigned                MAX_DELAY        = 7,
    parameter int unsigned                TIMEOUT_CYCLES   = 1023,
    parameter logic [ADC_DATA_WIDTH-1:0]  MARKER           = 8'hFF,
    localparam int unsigned               WORD_W = word_w(ADC_DATA_WIDTH, SAMPLES_PER_WORD),
    localparam int unsigned               DW     = delay_w(MAX_DELAY)
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [NUM_CH*WORD_W-1:0] din,
    input  logic                     train_start,
    input  logic [NUM_CH*DW-1:0]     manual_delay,
    input  logic                     manual_load,
    output logic [NUM_CH*WORD_W-1:0] dout,
    output logic                     dout_valid,
    output logic [NUM_CH*DW-1:0]     delay_out,
    output logic                     busy,
    output logic                     locked,
    output logic                     fail
);

    localparam int unsigned TW = clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = clog2(MAX_DELAY + 2);

    align_state_t        state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_CH-1:0]   seen_q, seen_d;
    logic [TW-1:0]       arrive_q [NUM_CH];
    logic [TW-1:0]       arrive_d [NUM_CH];
    logic [DW-1:0]       delay_q  [NUM_CH];
    logic [DW-1:0]       delay_d  [NUM_CH];
    logic [SW-1:0]       settle_q, settle_d;
    logic [TW-1:0]       arr_max, arr_min;
    logic                delay_chg;
    logic [NUM_CH*WORD_W-1:0] din_conv;

    // Sign conversion sits ahead of the delay line so reset still yields dout = 0
`ifdef ADC_TWOS_COMP_EN
    always_comb begin
        din_conv = din;
        for (int unsigned i = 0; i < NUM_CH*SAMPLES_PER_WORD; i++) begin
            din_conv[i*ADC_DATA_WIDTH + ADC_DATA_WIDTH - 1] = ~din[i*ADC_DATA_WIDTH + ADC_DATA_WIDTH - 1];
        end
    end
`else
    assign din_conv = din;
`endif

    // Latest and earliest marker arrival
    always_comb begin
        arr_max = arrive_q[0];
        arr_min = arrive_q[0];
        for (int unsigned c = 1; c < NUM_CH; c++) begin
            if (arrive_q[c] > arr_max) arr_max = arrive_q[c];
            if (arrive_q[c] < arr_min) arr_min = arrive_q[c];
        end
    end

    // Next state, search bookkeeping and delay updates
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        seen_d   = seen_q;
        arrive_d = arrive_q;
        delay_d  = delay_q;
        if (train_start) begin
            state_d = ST_ARM;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOCKED, ST_FAIL: begin
                    if (manual_load) begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (manual_delay[c*DW +: DW] > DW'(MAX_DELAY)) delay_d[c] = DW'(MAX_DELAY);
                            else                                           delay_d[c] = manual_delay[c*DW +: DW];
                        end
                    end
                end
                ST_ARM: begin
                    seen_d   = '0;
                    arrive_d = '{default: '0};
                    timer_d  = '0;
                    state_d  = ST_SEARCH;
                end
                ST_SEARCH: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if (!seen_q[c] && din[c*WORD_W +: ADC_DATA_WIDTH] == MARKER) begin
                            seen_d[c]   = 1'b1;
                            arrive_d[c] = timer_q;
                        end
                    end
                    if (&seen_d)                              state_d = ST_APPLY;
                    else if (timer_q == TW'(TIMEOUT_CYCLES))  state_d = ST_FAIL;
                    else                                      timer_d = timer_q + 1'b1;
                end
                ST_APPLY: begin
                    if ((arr_max - arr_min) > TW'(MAX_DELAY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        for (int unsigned c = 0; c < NUM_CH; c++) delay_d[c] = DW'(arr_max - arrive_q[c]);
                        state_d = ST_LOCKED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Settle counter restarts whenever any applied delay changes
    always_comb begin
        delay_chg = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (delay_d[c] != delay_q[c]) delay_chg = 1'b1;
        end
        if (delay_chg)             settle_d = SW'(MAX_DELAY + 1);
        else if (settle_q != '0)   settle_d = settle_q - 1'b1;
        else                       settle_d = settle_q;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            seen_q   <= '0;
            arrive_q <= '{default: '0};
            delay_q  <= '{default: '0};
            settle_q <= SW'(MAX_DELAY + 1);
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            seen_q   <= seen_d;
            arrive_q <= arrive_d;
            delay_q  <= delay_d;
            settle_q <= settle_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        adc_lane_delay #(
            .WIDTH     (WORD_W),
            .MAX_DELAY (MAX_DELAY),
            .DW        (DW)
        ) u_delay (
            .clk     (clk),
            .arst_n  (arst_n),
            .din_i   (din_conv[c*WORD_W +: WORD_W]),
            .delay_i (delay_q[c]),
            .dout_o  (dout[c*WORD_W +: WORD_W])
        );
        assign delay_out[c*DW +: DW] = delay_q[c];
    end

    assign busy       = (state_q == ST_ARM) || (state_q == ST_SEARCH) || (state_q == ST_APPLY);
    assign locked     = (state_q == ST_LOCKED);
    assign fail       = (state_q == ST_FAIL);
    assign dout_valid = (settle_q == '0);

endmodule

// File: tb/tb_adc_lane_align.sv
// Directed bench for adc_lane_align at default parameters.
module tb_adc_lane_align;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    adc_lane_align_if #(.NUM_CH(4), .WORD_W(32), .DW(3)) bus ();

    adc_lane_align #(
        .NUM_CH           (4),
        .ADC_DATA_WIDTH   (8),
        .SAMPLES_PER_WORD (4),
        .MAX_DELAY        (7),
        .TIMEOUT_CYCLES   (1023),
        .MARKER           (8'hFF)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .din          (bus.din),
        .train_start  (bus.train_start),
        .manual_delay (bus.manual_delay),
        .manual_load  (bus.manual_load),
        .dout         (bus.dout),
        .dout_valid   (bus.dout_valid),
        .delay_out    (bus.delay_out),
        .busy         (bus.busy),
        .locked       (bus.locked),
        .fail         (bus.fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Background words never carry the marker in sample 0; m selects marker channels
    task automatic set_din(input logic [3:0] m);
        for (int c = 0; c < 4; c++) begin
            bus.din[c*32 +: 32] = 32'h0A0B_0C10 + 32'(c);
            if (m[c]) bus.din[c*32 +: 8] = 8'hFF;
        end
    endtask

    function automatic logic [3:0] dout_marks();
        logic [3:0] m;
        for (int c = 0; c < 4; c++) m[c] = (bus.dout[c*32 +: 8] == 8'hFF);
        return m;
    endfunction

    // Start pulse, ARM cycle, then SEARCH cycles with markers at the given timer values
    task automatic do_train(input int a0, input int a1, input int a2, input int a3, input int ncyc);
        bus.train_start = 1'b1;
        tick();
        bus.train_start = 1'b0;
        tick();
        for (int t = 0; t < ncyc; t++) begin
            set_din({t == a3, t == a2, t == a1, t == a0});
            tick();
        end
        set_din(4'b0000);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #12;
        total++; if (bus.dout !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
        total++; if (bus.delay_out !== 12'h000) begin bad++; $display("FAIL reset_delay got=%h exp=000", bus.delay_out); end
        total++; if ({bus.busy, bus.locked, bus.fail, bus.dout_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.locked, bus.fail, bus.dout_valid});
        end
        @(posedge clk);
        #1 arst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (bus.dout_valid !== (i == 8)) begin
                bad++; $display("FAIL reset_valid_edge%0d got=%b exp=%b", i, bus.dout_valid, (i == 8));
            end
        end
    endtask

    task automatic test_train_ok();
        // markers in the start cycle and the ARM cycle must be ignored
        set_din(4'b1111);
        bus.train_start = 1'b1;
        tick();
        bus.train_start = 1'b0;
        total++; if ({bus.busy, bus.locked} !== 2'b10) begin bad++; $display("FAIL arm_flags got=%b exp=10", {bus.busy, bus.locked}); end
        tick();
        for (int t = 0; t < 8; t++) begin
            set_din((t == 5) ? 4'b0101 : (t == 6) ? 4'b1000 : (t == 7) ? 4'b0010 : 4'b0000);
            tick();
        end
        set_din(4'b0000);
        total++; if ({bus.busy, bus.locked} !== 2'b10) begin bad++; $display("FAIL apply_flags got=%b exp=10", {bus.busy, bus.locked}); end
        tick();
        total++; if (bus.delay_out !== {3'd1, 3'd2, 3'd0, 3'd2}) begin bad++; $display("FAIL train_delay got=%h exp=%h", bus.delay_out, {3'd1, 3'd2, 3'd0, 3'd2}); end
        total++; if ({bus.busy, bus.locked, bus.fail, bus.dout_valid} !== 4'b0100) begin
            bad++; $display("FAIL train_flags got=%b exp=0100", {bus.busy, bus.locked, bus.fail, bus.dout_valid});
        end
        for (int i = 0; i < 8; i++) tick();
        total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL train_valid got=%b exp=1", bus.dout_valid); end
        // replay the skewed markers; they must leave dout together
        for (int n = 0; n < 4; n++) begin
            set_din((n == 0) ? 4'b0101 : (n == 1) ? 4'b1000 : (n == 2) ? 4'b0010 : 4'b0000);
            tick();
            if (n >= 1) begin
                total++;
                if (dout_marks() !== ((n == 2) ? 4'b1111 : 4'b0000)) begin
                    bad++; $display("FAIL align_n%0d got=%b exp=%b", n, dout_marks(), (n == 2) ? 4'b1111 : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_manual_load();
        bus.manual_delay = {3'd0, 3'd5, 3'd0, 3'd3};
        bus.manual_load  = 1'b1;
        tick();
        bus.manual_load  = 1'b0;
        total++; if (bus.delay_out !== {3'd0, 3'd5, 3'd0, 3'd3}) begin bad++; $display("FAIL load_delay got=%h exp=%h", bus.delay_out, {3'd0, 3'd5, 3'd0, 3'd3}); end
        total++; if ({bus.locked, bus.dout_valid} !== 2'b10) begin bad++; $display("FAIL load_flags got=%b exp=10", {bus.locked, bus.dout_valid}); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (bus.dout_valid !== (i == 8)) begin bad++; $display("FAIL load_valid_edge%0d got=%b exp=%b", i, bus.dout_valid, (i == 8)); end
        end
        // ch2 now delays by 1+5 cycles
        for (int n = 0; n < 6; n++) begin
            set_din((n == 0) ? 4'b0100 : 4'b0000);
            tick();
            if (n >= 4) begin
                total++;
                if (dout_marks() !== ((n == 5) ? 4'b0100 : 4'b0000)) begin
                    bad++; $display("FAIL load_tap_n%0d got=%b exp=%b", n, dout_marks(), (n == 5) ? 4'b0100 : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_spread_edge();
        do_train(0, 7, 7, 7, 8);
        tick();
        total++; if (bus.delay_out !== 12'h007) begin bad++; $display("FAIL spread7_delay got=%h exp=007", bus.delay_out); end
        total++; if ({bus.locked, bus.fail} !== 2'b10) begin bad++; $display("FAIL spread7_flags got=%b exp=10", {bus.locked, bus.fail}); end
    endtask

    task automatic test_spread_fail();
        do_train(0, 9, 3, 9, 10);
        tick();
        total++; if ({bus.busy, bus.locked, bus.fail} !== 3'b001) begin bad++; $display("FAIL spread9_flags got=%b exp=001", {bus.busy, bus.locked, bus.fail}); end
        total++; if (bus.delay_out !== 12'h007) begin bad++; $display("FAIL spread9_delay got=%h exp=007", bus.delay_out); end
    endtask

    task automatic test_load_vs_start();
        bus.manual_delay = 12'h249;
        bus.manual_load  = 1'b1;
        bus.train_start  = 1'b1;
        tick();
        bus.manual_load  = 1'b0;
        bus.train_start  = 1'b0;
        total++; if ({bus.busy, bus.fail} !== 2'b10) begin bad++; $display("FAIL concur_flags got=%b exp=10", {bus.busy, bus.fail}); end
        total++; if (bus.delay_out !== 12'h007) begin bad++; $display("FAIL concur_delay got=%h exp=007", bus.delay_out); end
        tick();
        bus.manual_load = 1'b1;
        tick();
        bus.manual_load = 1'b0;
        total++; if ({bus.busy, bus.delay_out} !== {1'b1, 12'h007}) begin bad++; $display("FAIL busy_load got=%h exp=1007", {bus.busy, bus.delay_out}); end
    endtask

    task automatic test_timeout();
        int cnt;
        bus.train_start = 1'b1;
        tick();
        bus.train_start = 1'b0;
        tick();
        cnt = 0;
        while (cnt < 1100 && bus.fail !== 1'b1) begin
            set_din((cnt == 1) ? 4'b0111 : 4'b0000);
            tick();
            cnt++;
        end
        set_din(4'b0000);
        total++; if (cnt != 1024) begin bad++; $display("FAIL timeout_cycles got=%0d exp=1024", cnt); end
        total++; if ({bus.busy, bus.locked, bus.fail} !== 3'b001) begin bad++; $display("FAIL timeout_flags got=%b exp=001", {bus.busy, bus.locked, bus.fail}); end
        total++; if (bus.delay_out !== 12'h007) begin bad++; $display("FAIL timeout_delay got=%h exp=007", bus.delay_out); end
    endtask

    task automatic test_reset_mid();
        bus.train_start = 1'b1;
        tick();
        bus.train_start = 1'b0;
        tick();
        tick();
        arst_n = 1'b0;
        #2;
        total++; if ({bus.busy, bus.locked, bus.fail, bus.dout_valid} !== 4'b0000) begin
            bad++; $display("FAIL midrst_flags got=%b exp=0000", {bus.busy, bus.locked, bus.fail, bus.dout_valid});
        end
        total++; if ({bus.delay_out, bus.dout} !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", {bus.delay_out, bus.dout}); end
        arst_n = 1'b1;
    endtask

    task automatic test_sign();
        logic [31:0] exp_w;
`ifdef ADC_TWOS_COMP_EN
        exp_w = 32'hFF81_8000;
`else
        exp_w = 32'h7F01_0080;
`endif
        set_din(4'b0000);
        bus.din[31:0] = 32'h7F01_0080;
        tick();
        total++; if (bus.dout[31:0] !== exp_w) begin bad++; $display("FAIL sign_conv got=%h exp=%h", bus.dout[31:0], exp_w); end
    endtask

    initial begin
        bus.train_start  = 1'b0;
        bus.manual_load  = 1'b0;
        bus.manual_delay = '0;
        set_din(4'b0000);
        test_reset();
        test_train_ok();
        test_manual_load();
        test_spread_edge();
        test_spread_fail();
        test_load_vs_start();
        test_timeout();
        test_reset_mid();
        test_sign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
